// File: rtl/noc_frm_rx.sv
// rtl/noc_frm_rx.sv - receive deframer: response frame decode and 64-bit READ_RESP reassembly
module noc_frm_rx #(
    parameter logic [7:0] MY_ID = 8'h00,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frm_ctl,
    input  logic [7:0]       frm_data,
    output logic             rd_valid,
    output logic             rd_first,
    output logic             rd_last,
    output logic [63:0]      rd_data,
    output logic [7:0]       rd_src,
    output logic             wr_ack,
    output logic [7:0]       wr_count,
    output logic             msg_valid,
    output logic [7:0]       msg_code,
    output logic             proto_err,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEST,
        S_SRC,
        S_RDATA,
        S_WCNT,
        S_MSG
    } state_t;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_RD   = 3'b001;
    localparam logic [2:0] CMD_WR   = 3'b011;
    localparam logic [2:0] CMD_MSG  = 3'b100;

    state_t      state, state_n;
    logic [2:0]  cmd_q;
    logic [2:0]  len_q;
    logic        match_q;
    logic        first_q;
    logic [7:0]  bc;
    logic [63:0] asm_q;

    logic [2:0]  hdr_cmd;
    logic        hdr_start;
    logic        hdr_illegal;
    logic        body;
    logic [7:0]  len_mask;
    logic        last_byte;
    logic        word_done;
    logic [63:0] word_n;
    logic        rd_valid_n;
    logic        wr_ack_n;
    logic        msg_valid_n;
    logic        err_n;
    logic        cnt_inc;

    assign hdr_cmd     = frm_data[7:5];
    assign body        = !frm_ctl;
    assign hdr_start   = frm_ctl && (hdr_cmd == CMD_RD || hdr_cmd == CMD_WR || hdr_cmd == CMD_MSG);
    assign hdr_illegal = frm_ctl && !hdr_start && (hdr_cmd != CMD_IDLE);
    assign len_mask    = (8'd1 << len_q) - 8'd1;
    assign last_byte   = (bc == len_mask);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; any header byte restarts decoding regardless of state
    always_comb begin
        state_n = state;
        if (frm_ctl) begin
            state_n = hdr_start ? S_DEST : S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_n = S_IDLE;
                S_DEST:  state_n = S_SRC;
                S_SRC: begin
                    case (cmd_q)
                        CMD_RD:  state_n = S_RDATA;
                        CMD_WR:  state_n = S_WCNT;
                        default: state_n = S_MSG;
                    endcase
                end
                S_RDATA: state_n = last_byte ? S_IDLE : S_RDATA;
                S_WCNT:  state_n = S_IDLE;
                S_MSG:   state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Output decode: pulses and the word being completed this cycle
    always_comb begin
        word_n = asm_q;
        word_n[{bc[2:0], 3'b000} +: 8] = frm_data;
        word_done   = body && (state == S_RDATA) && ((bc[2:0] == 3'd7) || last_byte);
        rd_valid_n  = word_done && match_q;
        wr_ack_n    = body && (state == S_WCNT) && match_q;
        msg_valid_n = body && (state == S_MSG) && match_q;
        err_n       = (frm_ctl && (state != S_IDLE)) || hdr_illegal;
        cnt_inc     = match_q && body &&
                      (((state == S_RDATA) && last_byte) || (state == S_WCNT) || (state == S_MSG));
    end

    // Datapath: frame context, assembly register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q     <= CMD_IDLE;
            len_q     <= 3'd0;
            match_q   <= 1'b0;
            first_q   <= 1'b0;
            bc        <= 8'd0;
            asm_q     <= 64'd0;
            rd_valid  <= 1'b0;
            rd_first  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= 64'd0;
            rd_src    <= 8'd0;
            wr_ack    <= 1'b0;
            wr_count  <= 8'd0;
            msg_valid <= 1'b0;
            msg_code  <= 8'd0;
            proto_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            rd_valid  <= rd_valid_n;
            rd_first  <= rd_valid_n && first_q;
            rd_last   <= rd_valid_n && last_byte;
            wr_ack    <= wr_ack_n;
            msg_valid <= msg_valid_n;
            proto_err <= err_n;
            frame_cnt <= frame_cnt + CNT_W'(cnt_inc);
            if (rd_valid_n) begin
                rd_data <= word_n;
            end
            if (frm_ctl) begin
                // A header always drops any partial word of an aborted frame
                bc      <= 8'd0;
                asm_q   <= 64'd0;
                match_q <= 1'b0;
                first_q <= 1'b1;
                if (hdr_start) begin
                    cmd_q <= hdr_cmd;
                    len_q <= frm_data[2:0];
                end
            end else begin
                case (state)
                    S_DEST: match_q <= (frm_data == MY_ID);
                    S_SRC: begin
                        if (match_q) begin
                            rd_src <= frm_data;
                        end
                    end
                    S_RDATA: begin
                        bc <= bc + 8'd1;
                        if (word_done) begin
                            asm_q   <= 64'd0;
                            first_q <= 1'b0;
                        end else begin
                            asm_q <= word_n;
                        end
                    end
                    S_WCNT: begin
                        if (match_q) begin
                            wr_count <= frm_data;
                        end
                    end
                    S_MSG: begin
                        if (match_q) begin
                            msg_code <= frm_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noc_frm_rx.sv
// tb/tb_noc_frm_rx.sv - scoreboard bench for noc_frm_rx
module tb_noc_frm_rx;

    localparam int CNT_W = 16;
    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_MSG = 2;
    localparam int K_ERR = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             frm_ctl;
    logic [7:0]       frm_data;
    logic             rd_valid;
    logic             rd_first;
    logic             rd_last;
    logic [63:0]      rd_data;
    logic [7:0]       rd_src;
    logic             wr_ack;
    logic [7:0]       wr_count;
    logic             msg_valid;
    logic [7:0]       msg_code;
    logic             proto_err;
    logic [CNT_W-1:0] frame_cnt;

    typedef struct {
        int          kind;
        logic [63:0] data;
        logic        first;
        logic        last;
        logic [7:0]  src;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    noc_frm_rx #(.MY_ID(8'h00), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .frm_ctl   (frm_ctl),
        .frm_data  (frm_data),
        .rd_valid  (rd_valid),
        .rd_first  (rd_first),
        .rd_last   (rd_last),
        .rd_data   (rd_data),
        .rd_src    (rd_src),
        .wr_ack    (wr_ack),
        .wr_count  (wr_count),
        .msg_valid (msg_valid),
        .msg_code  (msg_code),
        .proto_err (proto_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input logic [63:0] data, input logic first,
                        input logic last, input logic [7:0] src);
        exp_t e;
        e.kind  = kind;
        e.data  = data;
        e.first = first;
        e.last  = last;
        e.src   = src;
        q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [63:0] val);
        exp_t e;
        chk("event_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            chk("event_data", val, e.data);
            if (kind == K_RD) begin
                chk("rd_first", 64'(rd_first), 64'(e.first));
                chk("rd_last", 64'(rd_last), 64'(e.last));
                chk("rd_src", 64'(rd_src), 64'(e.src));
            end
        end
    endtask

    // Scoreboard: every observed pulse must match the head of the expectation queue
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid)  pop_check(K_RD, rd_data);
            if (wr_ack)    pop_check(K_WR, 64'(wr_count));
            if (msg_valid) pop_check(K_MSG, 64'(msg_code));
            if (proto_err) pop_check(K_ERR, 64'd0);
        end
    end

    task automatic send(input logic c, input logic [7:0] d);
        @(posedge clk);
        #1;
        frm_ctl  = c;
        frm_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'h00);
    endtask

    task automatic check_cnt(input string tag);
        @(negedge clk);
        chk(tag, 64'(frame_cnt), 64'(exp_cnt));
        chk({tag, "_drained"}, 64'(q.size()), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"}, rd_data, 64'd0);
        chk({tag, "_rd_src"}, 64'(rd_src), 64'd0);
        chk({tag, "_wr_ack"}, 64'(wr_ack), 64'd0);
        chk({tag, "_wr_count"}, 64'(wr_count), 64'd0);
        chk({tag, "_msg_valid"}, 64'(msg_valid), 64'd0);
        chk({tag, "_msg_code"}, 64'(msg_code), 64'd0);
        chk({tag, "_proto_err"}, 64'(proto_err), 64'd0);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        frm_ctl  = 1'b0;
        frm_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Body bytes while idle are ignored
        idle(3);

        // READ_RESP len=4, 16 bytes 01..10, src 22
        push(K_RD, 64'h0807060504030201, 1'b1, 1'b0, 8'h22);
        push(K_RD, 64'h100F0E0D0C0B0A09, 1'b0, 1'b1, 8'h22);
        send(1'b1, 8'h24);
        send(1'b0, 8'h00);
        send(1'b0, 8'h22);
        for (int i = 1; i <= 16; i++) send(1'b0, 8'(i));
        exp_cnt = 1;
        idle(3);
        check_cnt("cnt_rd16");
        chk("rd_src_hold", 64'(rd_src), 64'h22);

        // READ_RESP len=1 partial word
        push(K_RD, 64'h000000000000BBAA, 1'b1, 1'b1, 8'h33);
        send(1'b1, 8'h21);
        send(1'b0, 8'h00);
        send(1'b0, 8'h33);
        send(1'b0, 8'hAA);
        send(1'b0, 8'hBB);
        exp_cnt = 2;
        idle(3);
        check_cnt("cnt_rd2");

        // WRITE_RESP then MESSAGE with no gap
        push(K_WR, 64'h40, 1'b0, 1'b0, 8'h00);
        push(K_MSG, 64'h5A, 1'b0, 1'b0, 8'h00);
        send(1'b1, 8'h60);
        send(1'b0, 8'h00);
        send(1'b0, 8'h11);
        send(1'b0, 8'h40);
        send(1'b1, 8'h80);
        send(1'b0, 8'h00);
        send(1'b0, 8'h11);
        send(1'b0, 8'h5A);
        exp_cnt = 4;
        idle(3);
        check_cnt("cnt_wr_msg");

        // READ_RESP len=4 aborted after 11 bytes by a WRITE_RESP header
        push(K_RD, 64'h0807060504030201, 1'b1, 1'b0, 8'h44);
        push(K_ERR, 64'h0, 1'b0, 1'b0, 8'h00);
        push(K_WR, 64'h77, 1'b0, 1'b0, 8'h00);
        send(1'b1, 8'h24);
        send(1'b0, 8'h00);
        send(1'b0, 8'h44);
        for (int i = 1; i <= 11; i++) send(1'b0, 8'(i));
        send(1'b1, 8'h60);
        send(1'b0, 8'h00);
        send(1'b0, 8'h44);
        send(1'b0, 8'h77);
        exp_cnt = 5;
        idle(3);
        check_cnt("cnt_abort");

        // Foreign dest, len=7: silent; then illegal header
        send(1'b1, 8'h27);
        send(1'b0, 8'h01);
        send(1'b0, 8'h55);
        for (int i = 0; i < 128; i++) send(1'b0, 8'(i + 3));
        idle(2);
        check_cnt("cnt_foreign");
        chk("rd_src_foreign", 64'(rd_src), 64'h44);
        push(K_ERR, 64'h0, 1'b0, 1'b0, 8'h00);
        send(1'b1, 8'hE0);
        idle(3);
        check_cnt("cnt_illegal");

        // Mid-frame IDLE header aborts a MESSAGE frame
        push(K_ERR, 64'h0, 1'b0, 1'b0, 8'h00);
        send(1'b1, 8'h80);
        send(1'b0, 8'h00);
        send(1'b1, 8'h00);
        idle(3);
        check_cnt("cnt_idle_abort");

        // Reset during byte 5 of a payload
        send(1'b1, 8'h24);
        send(1'b0, 8'h00);
        send(1'b0, 8'h66);
        for (int i = 1; i <= 4; i++) send(1'b0, 8'(i));
        @(posedge clk);
        #1;
        reset    = 1'b1;
        frm_ctl  = 1'b0;
        frm_data = 8'h05;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cnt = 0;

        push(K_WR, 64'h99, 1'b0, 1'b0, 8'h00);
        send(1'b1, 8'h60);
        send(1'b0, 8'h00);
        send(1'b0, 8'h66);
        send(1'b0, 8'h99);
        exp_cnt = 1;
        idle(4);
        check_cnt("cnt_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_frm_rx.md
Name: noc_frm_rx

Overview:
- Receive-side deframer directly downstream of the NoC interface top-level.
- Consumes the frm_ctl/frm_data byte stream and decodes response frames.
- Reassembles READ_RESP payloads into 64-bit words, little-endian, matching the permutation/m55 lane width.
- Reports WRITE_RESP acknowledgements, MESSAGE codes and protocol errors to the host-side bench/agent.

Parameters:
MY_ID, 8'h00, node id; frames whose dest byte differs are consumed silently with no outputs
CNT_W, 16, width of frame_cnt

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
frm_ctl  input  1  1 = frm_data is a header byte, 0 = body byte
frm_data  input  8  frame byte, one per cycle, no backpressure
rd_valid  output  1  one-cycle pulse, rd_data holds a payload word
rd_first  output  1  with rd_valid: first word of the frame
rd_last  output  1  with rd_valid: last word of the frame
rd_data  output  64  reassembled word, byte k of the word in bits [8k+7:8k]
rd_src  output  8  src id of the current READ_RESP, held until the next frame's src byte
wr_ack  output  1  one-cycle pulse, WRITE_RESP received
wr_count  output  8  byte count from WRITE_RESP, valid with wr_ack
msg_valid  output  1  one-cycle pulse, MESSAGE received
msg_code  output  8  message byte, valid with msg_valid
proto_err  output  1  one-cycle pulse on a protocol error
frame_cnt  output  CNT_W  count of accepted frames (dest == MY_ID), wraps at 2^CNT_W

Behaviour:
- Header byte fields (frm_ctl=1):
  - [7:5] cmd: 000 IDLE, 001 READ_RESP, 011 WRITE_RESP, 100 MESSAGE, others illegal.
  - [4:3] reserved, ignored.
  - [2:0] len: payload = 2^len bytes (1..128), used by READ_RESP only.
- Body layout after the header: dest byte, src byte, then:
  - READ_RESP: payload bytes.
  - WRITE_RESP: 1 count byte.
  - MESSAGE: 1 code byte.
- FSM states: IDLE, DEST, SRC, RDATA, WCNT, MSG. Reset -> IDLE.
- IDLE:
  - ctl=1 with cmd 001/011/100 -> DEST; latch cmd and len.
  - ctl=1 with cmd 000 -> stay IDLE.
  - ctl=1 with illegal cmd -> proto_err pulse, stay IDLE.
  - ctl=0 -> ignored, no error.
- DEST: latch dest; match = (dest == MY_ID); -> SRC.
- SRC: latch src, update rd_src if match; -> RDATA, WCNT or MSG by cmd. frame_cnt is not incremented here (see below).
- RDATA:
  - Byte counter bc counts 0..2^len-1, 8 bits, no overflow at len=7.
  - Bytes accumulate into a 64-bit shift/assembly register at lane bc[2:0].
  - Word emit when bc[2:0]==7 or bc==2^len-1:
    - rd_valid=1 next cycle (1-cycle latency after the completing byte), if match.
    - Unfilled upper lanes are zero (len 0..2 gives a partial word).
    - rd_first=1 on the first emitted word of the frame; rd_last=1 on the word containing the final byte.
  - After the final byte -> IDLE; frame_cnt++ if match.
- WCNT: wr_count<=byte, wr_ack pulse next cycle if match, frame_cnt++ if match; -> IDLE.
- MSG: msg_code<=byte, msg_valid pulse next cycle if match, frame_cnt++ if match; -> IDLE.
- Header arriving mid-frame (ctl=1 in DEST/SRC/RDATA/WCNT/MSG):
  - Abort the frame: proto_err pulse; already-emitted words stand, the partial word is discarded, no rd_last, frame_cnt unchanged.
  - The byte is then decoded as a new header in the same cycle, per the IDLE rules.
  - A mid-frame IDLE header (cmd 000) still aborts.
- Frame accepted iff dest matches and the frame completes without abort. Non-matching frames: all outputs stay quiet except proto_err.
- Back-to-back frames: a header may follow the last body byte in the next cycle, with no gap required.
- Reset values:
  - All pulses 0.
  - rd_data, rd_src, wr_count, msg_code = 0; frame_cnt = 0.
  - Assembly register and bc cleared.
  - Reset mid-frame discards the frame with no pulses.

Test Plan:
- READ_RESP len=4 (16 bytes 01..10), dest=MY_ID, src=8'h22 -> two rd_valid pulses:
  - rd_data=64'h0807060504030201 with rd_first=1.
  - rd_data=64'h100F0E0D0C0B0A09 with rd_last=1.
  - rd_src=8'h22; frame_cnt=1.
- READ_RESP len=1 (bytes AA,BB) -> one word 64'h000000000000BBAA with rd_first=rd_last=1.
- WRITE_RESP count 8'h40, then MESSAGE code 8'h5A back-to-back with no idle cycle -> wr_ack with wr_count=40, then msg_valid with msg_code=5A; frame_cnt=2.
- READ_RESP len=4 with a header byte injected after 11 payload bytes:
  - proto_err pulse.
  - First word emitted, partial second discarded, no rd_last.
  - The injected header starts a new frame that completes normally.
- dest=MY_ID+1 READ_RESP len=7 -> zero rd_valid pulses, frame_cnt unchanged. Then header 8'hE0 (illegal cmd 111) -> proto_err only.
- Reset asserted at byte 5 of a payload -> all outputs 0, FSM in IDLE. A following WRITE_RESP decodes correctly.
